// File: rtl/red_pkg.sv
// ============================================================================
// Module   : red_pkg
// Brief    : Widths, state encoding and nibble sign-extension for red_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package red_pkg;

  localparam int RED_DATA_W  = 16;
  localparam int RED_NIB_W   = 4;
  localparam int RED_NIBBLES = 4;
  localparam int RED_RES_W   = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } red_state_t;

  function automatic logic [RED_RES_W-1:0] sext_nib(input logic [RED_NIB_W-1:0] nib);
    return {{(RED_RES_W-RED_NIB_W){nib[RED_NIB_W-1]}}, nib};
  endfunction

endpackage

`default_nettype wire

// File: rtl/red_nib_add.sv
// ============================================================================
// Module   : red_nib_add
// Brief    : Combinational acc + sext(na) + sext(nb), 7-bit two's complement.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module red_nib_add
  import red_pkg::*;
(
  input  logic [RED_RES_W-1:0] acc,
  input  logic [RED_NIB_W-1:0] na,
  input  logic [RED_NIB_W-1:0] nb,
  output logic [RED_RES_W-1:0] sum
);

  // The total range -64..+56 fits in 7 bits, so modular addition never wraps.
  assign sum = acc + sext_nib(na) + sext_nib(nb);

endmodule

`default_nettype wire

// File: rtl/red_seq.sv
// ============================================================================
// Module   : red_seq
// Brief    : Multi-cycle RED sequencer, one nibble pair accumulated per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module red_seq
  import red_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RED_DATA_W-1:0] a,
  input  logic [RED_DATA_W-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RED_RES_W-1:0]  r,
  output logic                  busy
);

  red_state_t            state_q, state_d;
  logic [RED_DATA_W-1:0] a_q, a_d;
  logic [RED_DATA_W-1:0] b_q, b_d;
  logic [RED_RES_W-1:0]  acc_q, acc_d;
  logic [1:0]            idx_q, idx_d;

  logic [RED_NIB_W-1:0]  nib_a;
  logic [RED_NIB_W-1:0]  nib_b;
  logic [RED_RES_W-1:0]  sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    unique case (idx_q)
      2'd0:    begin nib_a = a_q[3:0];   nib_b = b_q[3:0];   end
      2'd1:    begin nib_a = a_q[7:4];   nib_b = b_q[7:4];   end
      2'd2:    begin nib_a = a_q[11:8];  nib_b = b_q[11:8];  end
      default: begin nib_a = a_q[15:12]; nib_b = b_q[15:12]; end
    endcase
  end

  red_nib_add u_nib_add (
    .acc (acc_q),
    .na  (nib_a),
    .nb  (nib_b),
    .sum (sum)
  );

  // Flush overrides every handshake; operand registers survive it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d = ACC;
            a_d     = a;
            b_d     = b;
            acc_d   = '0;
            idx_d   = '0;
          end
        end
        ACC: begin
          acc_d = sum;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == ACC) || (state_q == DONE);
    r         = acc_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_red_seq.sv
// ============================================================================
// Module   : tb_red_seq
// Brief    : Self-checking bench for red_seq against a cycle-level result model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_red_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [6:0]  r;
  logic        busy;

  int tests = 0;
  int fails = 0;

  red_seq dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int sx(input logic [3:0] n);
    return n[3] ? int'(n) - 16 : int'(n);
  endfunction

  // Sum of the first k nibble pairs, truncated to the 7-bit result.
  function automatic logic [6:0] partial(input logic [15:0] x, input logic [15:0] y, input int k);
    int s = 0;
    logic [15:0] tx = x;
    logic [15:0] ty = y;
    for (int i = 0; i < k; i++) begin
      s += sx(tx[3:0]) + sx(ty[3:0]);
      tx = tx >> 4;
      ty = ty >> 4;
    end
    return 7'(s);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: a transaction is pending for 4 accumulate cycles then waits in result-hold.
  bit          m_on = 1'b0;
  bit          m_pend = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_a = '0;
  logic [15:0] m_b = '0;
  logic [6:0]  m_r = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_pend = 1'b0; m_cnt = 0; m_r = '0; m_a = '0; m_b = '0;
    end else if (flush) begin
      m_pend = 1'b0; m_cnt = 0; m_r = '0;
    end else if (!m_pend) begin
      if (in_valid) begin
        m_pend = 1'b1; m_cnt = 0; m_a = a; m_b = b; m_r = '0;
      end
    end else if (m_cnt < 4) begin
      m_cnt++;
      m_r = partial(m_a, m_b, m_cnt);
    end else if (out_ready) begin
      m_pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("model_in_ready",  32'(in_ready),  32'(!m_pend));
      chk("model_out_valid", 32'(out_valid), 32'(m_pend && m_cnt == 4));
      chk("model_busy",      32'(busy),      32'(m_pend));
      chk("model_r",         32'(r),         32'(m_r));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [15:0] ta, input logic [15:0] tb, input logic [6:0] exp,
                     input int hold, input string name);
    int cyc;
    int bcnt;
    step();
    in_valid = 1'b1; a = ta; b = tb; out_ready = (hold == 0);
    step();
    in_valid = 1'b0;
    cyc = 0;
    bcnt = int'(busy);
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
      bcnt += int'(busy);
    end
    chk({name, "_latency"}, 32'(cyc), 32'd4);
    chk({name, "_r"}, 32'(r), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      step();
      chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_hold_r"}, 32'(r), 32'(exp));
      chk({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    bcnt += int'(busy);
    chk({name, "_back_idle"}, 32'(in_ready), 32'd1);
    if (hold == 0) chk({name, "_busy_cycles"}, 32'(bcnt), 32'd5);
    out_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    int seen;
    repeat (2) step();
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_r", 32'(r), 32'h00);

    txn(16'h1234, 16'h0000, 7'h0A, 0, "t1234");
    txn(16'h7777, 16'h7777, 7'h38, 0, "tmax");
    txn(16'h8888, 16'h8888, 7'h40, 0, "tmin");
    txn(16'hFFFF, 16'h0001, 7'h7D, 3, "tneg");

    // Back-to-back with in_valid held high; operands change while busy.
    in_valid = 1'b1; a = 16'h1234; b = 16'h1111; out_ready = 1'b1;
    step();
    a = 16'hF00F; b = 16'h0102;
    cyc = 0;
    while (!out_valid && cyc < 20) begin step(); cyc++; end
    chk("b2b_first_r", 32'(r), 32'(7'h0E));
    step();
    cyc = 0;
    while (!out_valid && cyc < 20) begin step(); cyc++; end
    chk("b2b_second_r", 32'(r), 32'(7'h01));
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;

    // Flush in the second accumulate cycle.
    step();
    in_valid = 1'b1; a = 16'h3333; b = 16'h2222;
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_acc_in_ready", 32'(in_ready), 32'd1);
    chk("flush_acc_r", 32'(r), 32'd0);
    seen = 0;
    repeat (8) begin step(); seen += int'(out_valid); end
    chk("flush_acc_no_valid", 32'(seen), 32'd0);

    // Flush while the result is held.
    in_valid = 1'b1; a = 16'h0101; b = 16'h0101;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin step(); cyc++; end
    chk("flush_done_pre_r", 32'(r), 32'(7'h04));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_done_dropped", 32'(out_valid), 32'd0);

    // Flush together with in_valid in IDLE: nothing accepted.
    flush = 1'b1; in_valid = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_busy", 32'(busy), 32'd0);

    // Reset mid-accumulation with in_valid high.
    in_valid = 1'b1; a = 16'h5555; b = 16'h1111;
    step();
    step();
    rst = 1'b1; a = 16'h2222;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    step();
    chk("rst_not_accepted", 32'(busy), 32'd0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
